reg_file_rename: RTL and testbench
==================================

// Module: reg_file_rename
// PURPOSE
//  Architectural register file plus rename table at the commit end of the ROB CDB.
//  - Consumes ROB commit broadcasts (valid/reg/tag/data) and retires values into x1..x31.
//  - Records ID rename requests (dest reg -> ROB tag).
//  - Answers dispatch source lookups with either a ready value or the producing ROB tag; dispatch then resolves the tag against the ROB.
// PARAMETERS
//  REG_NUM  32  architectural registers; x0 hardwired zero
//  REG_W    5   register index width
//  DATA_W   32  register data width
//  TAG_W    4   ROB tag width (16-entry ROB)
// PORTS
//  clk             in   1       clock
//  rst             in   1       synchronous reset, active-high
//  rdy             in   1       global ready; state holds when low
//  clear           in   1       mispredict flush from ROB
//  id_rename_valid in   1       ID allocates a ROB entry that writes a register
//  id_rename_reg   in   REG_W   destination register
//  id_rename_tag   in   TAG_W   ROB tag allocated for it
//  rs1_addr        in   REG_W   dispatch source 1 index
//  rs1_busy        out  1       1: value pending, use rs1_tag
//  rs1_tag         out  TAG_W   producing ROB tag; 0 when not busy
//  rs1_data        out  DATA_W  register value; 0 when busy
//  rs2_addr/rs2_busy/rs2_tag/rs2_data   same as rs1_*, for source 2
//  commit_valid    in   1       ROB commit broadcast valid
//  commit_reg      in   REG_W   committed destination register
//  commit_tag      in   TAG_W   ROB tag of the committing entry
//  commit_data     in   DATA_W  committed value
// BEHAVIOUR
//  State: regs[REG_NUM] DATA_W; busy[REG_NUM]; tag[REG_NUM] TAG_W.
//  Reset:
//   - all regs, busy and tag cleared to 0.
//   - outputs are combinational, so they read rsN_busy=0, rsN_tag=0, rsN_data=0.
//  x0: never written, never busy; rename/commit to reg 0 ignored; lookups of 0 return busy=0, data=0.
//  All state updates occur on posedge clk, only when rdy=1 and rst=0. rdy=0: no update; lookups remain live.
//  Commit (commit_valid, commit_reg!=0):
//   - regs[commit_reg] <= commit_data, unconditionally.
//   - busy[commit_reg] <= 0 only if busy=1 and tag[commit_reg]==commit_tag; a newer rename keeps the reg busy.
//  Rename (id_rename_valid, id_rename_reg!=0, clear=0):
//   - busy <= 1 and tag <= id_rename_tag.
//   - Overrides a same-cycle commit to the same reg: data is written, but the register stays busy with the new tag.
//  Clear:
//   - all busy bits <= 0 (tags don't care).
//   - a same-cycle commit still writes its data.
//   - a same-cycle rename is dropped.
//  Lookup, combinational, per port:
//   - Sees state before this cycle's rename, so an instruction reading its own dest (add x1,x1,x2) gets the old mapping.
//   - Commit bypass: if commit_valid, rs==commit_reg!=0, busy[rs]=1 and tag[rs]==commit_tag, return busy=0, data=commit_data.
//   - Otherwise return busy[rs], with tag[rs] if busy or regs[rs] if not busy.
//   - The bypass ignores rdy and clear.
//  No handshake or backpressure: ROB guarantees at most one commit per cycle; ID guarantees tag uniqueness.
//  Tag wrap: tags are reused modulo 2^TAG_W; correctness relies on the tag-match check at commit.
// TESTING
//  1. Reset, then lookup x5 -> busy=0, data=0; rename x0 tag 3, lookup x0 -> busy=0, data=0.
//  2. Rename x5 tag 2; next cycle lookup x5 -> busy=1, tag=2. Commit x5 tag 2 data 0x1234 -> same-cycle lookup busy=0, data=0x1234; next cycle too.
//  3. Rename x7 tag 1, then rename x7 tag 4. Commit x7 tag 1 data 0xAA -> regs=0xAA, still busy with tag=4. Commit tag 4 data 0xBB -> busy=0, data=0xBB.
//  4. Same cycle: commit x3 tag 6 data 0x55 and rename x3 tag 9 -> next cycle busy=1, tag=9; after clear, data=0x55.
//  5. Rename x1..x4 (tags 0..3), assert clear together with commit x2 tag 1 data 0x77 and rename x8 -> all not busy, x2=0x77, x8 not busy.
//  6. rdy=0 while rename x9 tag 5 -> no effect, lookup x9 busy=0; tag wrap: rename x10 tag 15 then tag 0, commit tag 15 -> stays busy with tag 0.

Source files
------------

// File: rtl/reg_file_rename.sv
// Architectural register file plus rename table; commits retire into x1..x31, renames mark regs busy.
// Lookups are combinational (pre-rename state, with same-cycle commit bypass); state updates when rdy_i is high.
module reg_file_rename #(
    parameter int REG_NUM = 32,
    parameter int REG_W   = 5,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy_i,
    input  logic              clear_i,
    input  logic              id_rename_valid_i,
    input  logic [REG_W-1:0]  id_rename_reg_i,
    input  logic [TAG_W-1:0]  id_rename_tag_i,
    input  logic [REG_W-1:0]  rs1_addr_i,
    output logic              rs1_busy_o,
    output logic [TAG_W-1:0]  rs1_tag_o,
    output logic [DATA_W-1:0] rs1_data_o,
    input  logic [REG_W-1:0]  rs2_addr_i,
    output logic              rs2_busy_o,
    output logic [TAG_W-1:0]  rs2_tag_o,
    output logic [DATA_W-1:0] rs2_data_o,
    input  logic              commit_valid_i,
    input  logic [REG_W-1:0]  commit_reg_i,
    input  logic [TAG_W-1:0]  commit_tag_i,
    input  logic [DATA_W-1:0] commit_data_i
);

    typedef struct packed {
        logic              busy;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } lookup_t;

    logic [REG_NUM-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [REG_NUM-1:0]             busy_q, busy_d;
    logic [REG_NUM-1:0][TAG_W-1:0]  tag_q,  tag_d;

    logic commit_en, rename_en;
    assign commit_en = commit_valid_i && (commit_reg_i != '0);
    assign rename_en = id_rename_valid_i && (id_rename_reg_i != '0) && !clear_i;

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        if (commit_en) begin
            regs_d[commit_reg_i] = commit_data_i;
            // Only the youngest producer may clear busy; a stale commit leaves the newer mapping alone.
            if (busy_q[commit_reg_i] && (tag_q[commit_reg_i] == commit_tag_i))
                busy_d[commit_reg_i] = 1'b0;
        end
        if (clear_i) begin
            busy_d = '0;
        end else if (rename_en) begin
            busy_d[id_rename_reg_i] = 1'b1;
            tag_d[id_rename_reg_i]  = id_rename_tag_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
            busy_q <= '0;
            tag_q  <= '0;
        end else if (rdy_i) begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

    function automatic lookup_t lookup(input logic [REG_W-1:0] a);
        lookup_t r;
        r = '0;
        if (a != '0) begin
            if (commit_valid_i && (commit_reg_i == a) && busy_q[a] && (tag_q[a] == commit_tag_i)) begin
                r.data = commit_data_i;
            end else if (busy_q[a]) begin
                r.busy = 1'b1;
                r.tag  = tag_q[a];
            end else begin
                r.data = regs_q[a];
            end
        end
        return r;
    endfunction

    lookup_t rs1_q, rs2_q;

    always_comb begin
        rs1_q = lookup(rs1_addr_i);
        rs2_q = lookup(rs2_addr_i);
    end

    assign rs1_busy_o = rs1_q.busy;
    assign rs1_tag_o  = rs1_q.tag;
    assign rs1_data_o = rs1_q.data;
    assign rs2_busy_o = rs2_q.busy;
    assign rs2_tag_o  = rs2_q.tag;
    assign rs2_data_o = rs2_q.data;

endmodule

// File: tb/tb_reg_file_rename.sv
// Bench for reg_file_rename: directed vector table, then random traffic against an array-based reference model.
module tb_reg_file_rename;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy, clr, rv, cv;
    logic [4:0]  rreg, creg, a1, a2;
    logic [3:0]  rtag, ctag;
    logic [31:0] cdat;
    logic        b1, b2;
    logic [3:0]  t1, t2;
    logic [31:0] d1, d2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_file_rename dut (
        .clk(clk), .rst(rst), .rdy_i(rdy), .clear_i(clr),
        .id_rename_valid_i(rv), .id_rename_reg_i(rreg), .id_rename_tag_i(rtag),
        .rs1_addr_i(a1), .rs1_busy_o(b1), .rs1_tag_o(t1), .rs1_data_o(d1),
        .rs2_addr_i(a2), .rs2_busy_o(b2), .rs2_tag_o(t2), .rs2_data_o(d2),
        .commit_valid_i(cv), .commit_reg_i(creg), .commit_tag_i(ctag), .commit_data_i(cdat)
    );

    // Reference state: what each architectural register holds and who will produce it next.
    logic [31:0] m_regs [32];
    logic        m_busy [32];
    logic [3:0]  m_tag  [32];

    function automatic logic [36:0] E(input logic b, input logic [3:0] t, input logic [31:0] d);
        return {b, t, d};
    endfunction

    function automatic logic [36:0] model_lookup(input logic [4:0] a);
        if (a == 0) return '0;
        if (cv && creg == a && m_busy[a] && m_tag[a] == ctag) return E(1'b0, 4'd0, cdat);
        if (m_busy[a]) return E(1'b1, m_tag[a], 32'd0);
        return E(1'b0, 4'd0, m_regs[a]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
        end
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else if (rdy) begin
            if (cv && creg != 0) begin
                m_regs[creg] = cdat;
                if (m_busy[creg] && m_tag[creg] == ctag) m_busy[creg] = 1'b0;
            end
            if (clr) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else if (rv && rreg != 0) begin
                m_busy[rreg] = 1'b1;
                m_tag[rreg]  = rtag;
            end
        end
    endtask

    task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got busy=%0b tag=%0d data=%h, expected busy=%0b tag=%0d data=%h",
                     name, act[36], act[35:32], act[31:0], exp[36], exp[35:32], exp[31:0]);
        end
    endtask

    task automatic idle();
        rdy = 1'b1; clr = 1'b0; rv = 1'b0; rreg = '0; rtag = '0;
        cv = 1'b0; creg = '0; ctag = '0; cdat = '0; a1 = '0; a2 = '0;
    endtask

    // One clock: inputs already driven; sample lookups at negedge, then advance state.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        logic        rdy, clr, rv;
        logic [4:0]  rreg;
        logic [3:0]  rtag;
        logic        cv;
        logic [4:0]  creg;
        logic [3:0]  ctag;
        logic [31:0] cdat;
        logic [4:0]  a1;
        logic [36:0] e1;
        logic [4:0]  a2;
        logic [36:0] e2;
    } vec_t;

    function automatic vec_t mk(input logic ry, input logic c, input logic v, input logic [4:0] rr,
                                input logic [3:0] rt, input logic cvv, input logic [4:0] cr,
                                input logic [3:0] ct, input logic [31:0] cd, input logic [4:0] x1,
                                input logic [36:0] ex1, input logic [4:0] x2, input logic [36:0] ex2);
        vec_t r;
        r.rdy = ry; r.clr = c; r.rv = v; r.rreg = rr; r.rtag = rt;
        r.cv = cvv; r.creg = cr; r.ctag = ct; r.cdat = cd;
        r.a1 = x1; r.e1 = ex1; r.a2 = x2; r.e2 = ex2;
        return r;
    endfunction

    vec_t tbl[$];
    localparam logic [36:0] Z = 37'd0;

    initial begin
        idle();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        a1 = 5'd5; a2 = 5'd31;
        @(negedge clk);
        chk("reset_rs1", {b1, t1, d1}, Z);
        chk("reset_rs2", {b2, t2, d2}, Z);
        tick();

        //                rdy clr rv rreg  rtag cv creg  ctag cdat          a1     e1                          a2     e2
        tbl.push_back(mk(1, 0, 1, 5'd0,  4'd3, 0, 5'd0, 4'd0, 32'h0,      5'd5,  Z,                          5'd0,  Z));
        tbl.push_back(mk(1, 0, 0, 5'd0,  4'd0, 0, 5'd0, 4'd0, 32'h0,      5'd0,  Z,                          5'd5,  Z));
        tbl.push_back(mk(1, 0, 1, 5'd5,  4'd2, 0, 5'd0, 4'd0, 32'h0,      5'd5,  Z,                          5'd0,  Z));
        tbl.push_back(mk(1, 0, 0, 5'd0,  4'd0, 0, 5'd0, 4'd0, 32'h0,      5'd5,  E(1, 4'd2, 0),              5'd5,  E(1, 4'd2, 0)));
        tbl.push_back(mk(1, 0, 0, 5'd0,  4'd0, 1, 5'd5, 4'd2, 32'h1234,   5'd5,  E(0, 0, 32'h1234),          5'd5,  E(0, 0, 32'h1234)));
        tbl.push_back(mk(1, 0, 0, 5'd0,  4'd0, 0, 5'd0, 4'd0, 32'h0,      5'd5,  E(0, 0, 32'h1234),          5'd0,  Z));
        tbl.push_back(mk(1, 0, 1, 5'd7,  4'd1, 0, 5'd0, 4'd0, 32'h0,      5'd7,  Z,                          5'd0,  Z));
        tbl.push_back(mk(1, 0, 1, 5'd7,  4'd4, 0, 5'd0, 4'd0, 32'h0,      5'd7,  E(1, 4'd1, 0),              5'd0,  Z));
        tbl.push_back(mk(1, 0, 0, 5'd0,  4'd0, 1, 5'd7, 4'd1, 32'hAA,     5'd7,  E(1, 4'd4, 0),              5'd0,  Z));
        tbl.push_back(mk(1, 0, 0, 5'd0,  4'd0, 1, 5'd7, 4'd4, 32'hBB,     5'd7,  E(0, 0, 32'hBB),            5'd0,  Z));
        tbl.push_back(mk(1, 0, 0, 5'd0,  4'd0, 0, 5'd0, 4'd0, 32'h0,      5'd7,  E(0, 0, 32'hBB),            5'd0,  Z));
        tbl.push_back(mk(1, 0, 1, 5'd3,  4'd9, 1, 5'd3, 4'd6, 32'h55,     5'd3,  Z,                          5'd0,  Z));
        tbl.push_back(mk(1, 0, 0, 5'd0,  4'd0, 0, 5'd0, 4'd0, 32'h0,      5'd3,  E(1, 4'd9, 0),              5'd0,  Z));
        tbl.push_back(mk(1, 1, 0, 5'd0,  4'd0, 0, 5'd0, 4'd0, 32'h0,      5'd3,  E(1, 4'd9, 0),              5'd0,  Z));
        tbl.push_back(mk(1, 0, 0, 5'd0,  4'd0, 0, 5'd0, 4'd0, 32'h0,      5'd3,  E(0, 0, 32'h55),            5'd0,  Z));
        tbl.push_back(mk(1, 0, 1, 5'd1,  4'd0, 0, 5'd0, 4'd0, 32'h0,      5'd1,  Z,                          5'd0,  Z));
        tbl.push_back(mk(1, 0, 1, 5'd2,  4'd1, 0, 5'd0, 4'd0, 32'h0,      5'd1,  E(1, 4'd0, 0),              5'd0,  Z));
        tbl.push_back(mk(1, 0, 1, 5'd3,  4'd2, 0, 5'd0, 4'd0, 32'h0,      5'd2,  E(1, 4'd1, 0),              5'd0,  Z));
        tbl.push_back(mk(1, 0, 1, 5'd4,  4'd3, 0, 5'd0, 4'd0, 32'h0,      5'd2,  E(1, 4'd1, 0),              5'd3,  E(1, 4'd2, 0)));
        tbl.push_back(mk(1, 1, 1, 5'd8,  4'd5, 1, 5'd2, 4'd1, 32'h77,     5'd2,  E(0, 0, 32'h77),            5'd4,  E(1, 4'd3, 0)));
        tbl.push_back(mk(1, 0, 0, 5'd0,  4'd0, 0, 5'd0, 4'd0, 32'h0,      5'd2,  E(0, 0, 32'h77),            5'd3,  E(0, 0, 32'h55)));
        tbl.push_back(mk(1, 0, 0, 5'd0,  4'd0, 0, 5'd0, 4'd0, 32'h0,      5'd8,  Z,                          5'd4,  Z));
        tbl.push_back(mk(1, 0, 0, 5'd0,  4'd0, 0, 5'd0, 4'd0, 32'h0,      5'd1,  Z,                          5'd0,  Z));
        tbl.push_back(mk(0, 0, 1, 5'd9,  4'd5, 0, 5'd0, 4'd0, 32'h0,      5'd9,  Z,                          5'd0,  Z));
        tbl.push_back(mk(1, 0, 0, 5'd0,  4'd0, 0, 5'd0, 4'd0, 32'h0,      5'd9,  Z,                          5'd0,  Z));
        tbl.push_back(mk(1, 0, 1, 5'd10, 4'd15, 0, 5'd0, 4'd0, 32'h0,     5'd10, Z,                          5'd0,  Z));
        tbl.push_back(mk(1, 0, 1, 5'd10, 4'd0, 0, 5'd0, 4'd0, 32'h0,      5'd10, E(1, 4'd15, 0),             5'd0,  Z));
        tbl.push_back(mk(1, 0, 0, 5'd0,  4'd0, 1, 5'd10, 4'd15, 32'hCC,   5'd10, E(1, 4'd0, 0),              5'd0,  Z));
        tbl.push_back(mk(1, 0, 0, 5'd0,  4'd0, 0, 5'd0, 4'd0, 32'h0,      5'd10, E(1, 4'd0, 0),              5'd10, E(1, 4'd0, 0)));
        tbl.push_back(mk(0, 0, 0, 5'd0,  4'd0, 1, 5'd10, 4'd0, 32'hDD,    5'd10, E(0, 0, 32'hDD),            5'd0,  Z));
        tbl.push_back(mk(1, 0, 0, 5'd0,  4'd0, 0, 5'd0, 4'd0, 32'h0,      5'd10, E(1, 4'd0, 0),              5'd0,  Z));
        tbl.push_back(mk(1, 0, 0, 5'd0,  4'd0, 1, 5'd10, 4'd0, 32'hEE,    5'd10, E(0, 0, 32'hEE),            5'd0,  Z));
        tbl.push_back(mk(1, 0, 0, 5'd0,  4'd0, 0, 5'd0, 4'd0, 32'h0,      5'd10, E(0, 0, 32'hEE),            5'd0,  Z));

        for (int i = 0; i < tbl.size(); i++) begin
            rdy = tbl[i].rdy; clr = tbl[i].clr; rv = tbl[i].rv; rreg = tbl[i].rreg; rtag = tbl[i].rtag;
            cv = tbl[i].cv; creg = tbl[i].creg; ctag = tbl[i].ctag; cdat = tbl[i].cdat;
            a1 = tbl[i].a1; a2 = tbl[i].a2;
            @(negedge clk);
            chk($sformatf("vec%0d_rs1", i), {b1, t1, d1}, tbl[i].e1);
            chk($sformatf("vec%0d_rs2", i), {b2, t2, d2}, tbl[i].e2);
            tick();
        end

        for (int n = 0; n < 3000; n++) begin
            logic [4:0] r;
            rdy  = ($urandom_range(0, 9) != 0);
            clr  = ($urandom_range(0, 19) == 0);
            rv   = $urandom_range(0, 1);
            rreg = 5'($urandom_range(0, 7));
            rtag = 4'($urandom_range(0, 15));
            cv   = $urandom_range(0, 1);
            r    = 5'($urandom_range(0, 7));
            creg = r;
            ctag = (m_busy[r] && $urandom_range(0, 3) != 0) ? m_tag[r] : 4'($urandom_range(0, 15));
            cdat = $urandom;
            a1   = ($urandom_range(0, 1) != 0) ? creg : 5'($urandom_range(0, 7));
            a2   = 5'($urandom_range(0, 31));
            @(negedge clk);
            chk($sformatf("rand%0d_rs1", n), {b1, t1, d1}, model_lookup(a1));
            chk($sformatf("rand%0d_rs2", n), {b2, t2, d2}, model_lookup(a2));
            tick();
        end

        // Reset mid-stream must wipe data and busy even with a rename presented alongside it.
        idle();
        cv = 1'b1; creg = 5'd6; ctag = 4'd0; cdat = 32'hF00D;
        tick();
        rst = 1'b1; cv = 1'b0; rv = 1'b1; rreg = 5'd6; rtag = 4'd7;
        tick();
        rst = 1'b0; idle();
        a1 = 5'd6; a2 = 5'd2;
        @(negedge clk);
        chk("rerst_rs1", {b1, t1, d1}, Z);
        chk("rerst_rs2", {b2, t2, d2}, Z);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
